pkt_fifo_ctrl: RTL and testbench
================================

Name: pkt_fifo_ctrl

Overview:
- Store-and-forward packet FIFO controller for the network stack.
- Drives an external single-clock dual-port 8-bit BRAM of depth P_NUM_BRAM*1024: write port A, read port B with 1-cycle registered read.
- Accepts byte frames from the MAC receive side and commits only complete, good frames.
- Replays committed frames to the downstream parser with valid/ready/last framing.

Parameters:
- P_NUM_BRAM, 4, BRAM count; buffer depth D = P_NUM_BRAM*1024 bytes, AW = clog2(D).
- P_MAX_FRAMES, 16, depth of the internal committed-frame length queue (power of 2).

Ports:
- clk  in  1  system clock; BRAM ports A and B are both clocked by it.
- rst_n  in  1  synchronous reset, active-low.
- s_data  in  8  ingress byte.
- s_valid  in  1  ingress byte valid.
- s_last  in  1  final byte of frame.
- s_drop  in  1  qualified with s_valid&s_last: discard the frame (bad FCS).
- s_ready  out  1  ingress ready.
- m_data  out  8  egress byte.
- m_valid  out  1  egress valid.
- m_last  out  1  final byte of egress frame.
- m_ready  in  1  egress ready.
- bram_wr_addr  out  AW  BRAM port A address.
- bram_wr_en  out  1  BRAM port A write enable.
- bram_wr_data  out  8  BRAM port A data.
- bram_rd_addr  out  AW  BRAM port B address.
- bram_rd_data  in  8  BRAM port B data, valid 1 cycle after bram_rd_addr.
- frame_count  out  clog2(P_MAX_FRAMES)+1  committed frames not yet fully sent.
- drop_pulse  out  1  1-cycle pulse per discarded frame.

Behaviour:
- Pointers are AW+1 bits, binary, wrapping modulo 2^(AW+1); BRAM address is the low AW bits.
- used = wr_ptr - rd_ptr. rd_ptr advances only on an m_valid&m_ready handshake, never on read issue.
- Write FSM, IDLE/WRITE/DISCARD:
  - IDLE: s_ready = (frame_count < P_MAX_FRAMES). A handshake writes the byte, latches frame_start = wr_ptr and moves to WRITE (stays IDLE if s_last).
  - WRITE: s_ready = 1. Each handshake drives bram_wr_en combinationally from the handshake, bram_wr_addr = wr_ptr, and increments wr_ptr.
  - Overflow: a byte arriving when used == D is not written. wr_ptr rewinds to frame_start, drop_pulse fires, and the FSM enters DISCARD (or IDLE if that byte is s_last).
  - DISCARD: s_ready = 1, bytes swallowed, no writes, IDLE after s_last.
- Commit: on the s_last handshake with s_drop=0 and no overflow, push length = wr_ptr+1-frame_start (AW+1 bits; D allowed) into the length queue.
- Drop: on the s_last handshake with s_drop=1, skip the write, rewind wr_ptr to frame_start and pulse drop_pulse. s_drop without s_last is ignored.
- Read FSM, IDLE/FETCH/STREAM:
  - IDLE: leave when the length queue is non-empty. Pop the length into a down-counter, issue bram_rd_addr = rd_issue_ptr, go to FETCH.
  - FETCH: the byte lands next cycle.
  - STREAM: a 2-entry output skid buffer gives 1 byte/cycle with m_ready held high, and is never overrun when m_ready is low.
  - m_last is asserted with the byte where the down-counter reaches 1.
  - After the m_last handshake, return to IDLE, or go directly to FETCH if another length is queued.
- Latency: a frame committed by the s_last handshake at edge T, with read FSM idle, has m_valid=1 in the cycle after edge T+3.
- frame_count: +1 on commit, -1 on the m_last handshake; unchanged when both occur in the same cycle.
- Reads never cross into uncommitted data; the length queue guarantees this.
- Reset (rst_n=0 at a clk edge, including mid-frame or mid-egress):
  - All pointers, counters and the length queue clear; both FSMs go to IDLE.
  - s_ready=0, m_valid=0, m_last=0, m_data=0, bram_wr_en=0, bram addresses 0, frame_count=0, drop_pulse=0.
  - The partial frame is lost; BRAM contents are don't-care.
  - s_ready asserts in the first cycle after rst_n deasserts.

Test Plan:
- 64-byte frame 0x00..0x3F, m_ready=1: frame_count goes to 1, m_valid 3 cycles after commit, 64 bytes back-to-back in order, m_last on 0x3F, frame_count returns to 0.
- Frame with s_drop=1 on s_last, followed by a 10-byte good frame: one drop_pulse; egress shows only the 10-byte frame; wr_ptr equals the pre-drop value + 10.
- P_NUM_BRAM=1: 1000-byte frame held by m_ready=0, then a 100-byte frame: overflow at used == 1024 gives drop_pulse and DISCARD; after release, only the 1000-byte frame egresses.
- 16 one-byte frames with m_ready=0: s_ready goes low with frame_count=16; one pop re-enables s_ready; a simultaneous commit and pop keeps the count constant.
- Random m_ready at 50% over frames wrapping the buffer 3 times: byte-exact scoreboard match, no m_data change while m_valid & !m_ready.
- rst_n=0 for 1 cycle mid-ingress and mid-egress: all outputs go to their reset values; a subsequent 8-byte frame passes cleanly.

Source files
------------

// File: rtl/pkt_fifo_ctrl.sv
// Store-and-forward packet FIFO controller: commits good frames into an
// external BRAM and replays them downstream with valid/ready/last framing.
module pkt_fifo_ctrl #(
  parameter int P_NUM_BRAM   = 4,
  parameter int P_MAX_FRAMES = 16,
  localparam int D  = P_NUM_BRAM * 1024,
  localparam int AW = $clog2(D),
  localparam int FW = $clog2(P_MAX_FRAMES) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  input  logic          s_last,
  input  logic          s_drop,
  output logic          s_ready,
  output logic [7:0]    m_data,
  output logic          m_valid,
  output logic          m_last,
  input  logic          m_ready,
  output logic [AW-1:0] bram_wr_addr,
  output logic          bram_wr_en,
  output logic [7:0]    bram_wr_data,
  output logic [AW-1:0] bram_rd_addr,
  input  logic [7:0]    bram_rd_data,
  output logic [FW-1:0] frame_count,
  output logic          drop_pulse
);

  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] PD  = (AW+1)'(D);
  localparam logic [FW-1:0] F1 = FW'(1);

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DISCARD} wst_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rdst_t;

  wst_t  wst, wst_nx;
  rdst_t rdst, rdst_nx;

  logic [AW:0] wr_ptr, rd_ptr, rd_iss, frm_start, start, used, rem;
  logic [AW:0] lq [P_MAX_FRAMES];
  logic [FW-1:0] lq_wp, lq_rp;
  logic s_hs, wr, commit, rewind, ovf;
  logic lq_empty, lq_pop, issue, pend, pend_last, m_hs;
  logic [7:0] obuf [2];
  logic [1:0] olast, ocnt;
  logic owp, orp;

  assign used  = wr_ptr - rd_ptr;
  assign ovf   = (used == PD);
  assign start = (wst == W_IDLE) ? wr_ptr : frm_start;

  always_comb begin
    wst_nx     = wst;
    s_ready    = 1'b0;
    wr         = 1'b0;
    commit     = 1'b0;
    rewind     = 1'b0;
    drop_pulse = 1'b0;
    unique case (wst)
      W_IDLE:  s_ready = rst_n && (frame_count < FW'(P_MAX_FRAMES));
      default: s_ready = rst_n;
    endcase
    s_hs = s_valid && s_ready;
    if (s_hs) begin
      if (wst == W_DISCARD) begin
        if (s_last) wst_nx = W_IDLE;
      end else if (ovf) begin
        rewind     = 1'b1;
        drop_pulse = 1'b1;
        wst_nx     = s_last ? W_IDLE : W_DISCARD;
      end else if (s_last && s_drop) begin
        rewind     = 1'b1;
        drop_pulse = 1'b1;
        wst_nx     = W_IDLE;
      end else begin
        wr     = 1'b1;
        commit = s_last;
        wst_nx = s_last ? W_IDLE : W_WRITE;
      end
    end
  end

  assign bram_wr_en   = wr;
  assign bram_wr_addr = wr_ptr[AW-1:0];
  assign bram_wr_data = s_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wst       <= W_IDLE;
      wr_ptr    <= '0;
      frm_start <= '0;
    end else begin
      wst <= wst_nx;
      if (s_hs && wst == W_IDLE) frm_start <= wr_ptr;
      if (wr) wr_ptr <= wr_ptr + ONE;
      else if (rewind) wr_ptr <= start;
    end
  end

  // Lengths of committed frames; the reader never looks past these.
  always_ff @(posedge clk) begin
    if (commit) lq[lq_wp[FW-2:0]] <= wr_ptr + ONE - start;
  end

  assign lq_empty = (lq_wp == lq_rp);
  assign m_hs     = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lq_wp       <= '0;
      lq_rp       <= '0;
      frame_count <= '0;
    end else begin
      if (commit) lq_wp <= lq_wp + F1;
      if (lq_pop) lq_rp <= lq_rp + F1;
      unique case ({commit, m_hs && m_last})
        2'b10:   frame_count <= frame_count + F1;
        2'b01:   frame_count <= frame_count - F1;
        default: frame_count <= frame_count;
      endcase
    end
  end

  always_comb begin
    rdst_nx = rdst;
    lq_pop  = 1'b0;
    issue   = 1'b0;
    unique case (rdst)
      R_IDLE: begin
        if (!lq_empty) begin
          lq_pop  = 1'b1;
          rdst_nx = R_FETCH;
        end
      end
      R_FETCH: begin
        issue   = 1'b1;
        rdst_nx = R_STREAM;
      end
      R_STREAM: begin
        // Credit: buffered + in-flight bytes must fit the 2-entry skid.
        issue = (rem != '0) &&
                ({1'b0, ocnt} + {2'b0, pend} < 3'd2 + {2'b0, m_hs});
        if (m_hs && m_last) begin
          if (!lq_empty) begin
            lq_pop  = 1'b1;
            rdst_nx = R_FETCH;
          end else begin
            rdst_nx = R_IDLE;
          end
        end
      end
      default: rdst_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdst      <= R_IDLE;
      rd_ptr    <= '0;
      rd_iss    <= '0;
      rem       <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      obuf[0]   <= '0;
      obuf[1]   <= '0;
      olast     <= '0;
      ocnt      <= '0;
      owp       <= 1'b0;
      orp       <= 1'b0;
    end else begin
      rdst      <= rdst_nx;
      pend      <= issue;
      pend_last <= issue && (rem == ONE);
      if (lq_pop) rem <= lq[lq_rp[FW-2:0]];
      else if (issue) rem <= rem - ONE;
      if (issue) rd_iss <= rd_iss + ONE;
      if (m_hs) rd_ptr <= rd_ptr + ONE;
      if (pend) begin
        obuf[owp]  <= bram_rd_data;
        olast[owp] <= pend_last;
        owp        <= ~owp;
      end
      if (m_hs) orp <= ~orp;
      ocnt <= ocnt + {1'b0, pend} - {1'b0, m_hs};
    end
  end

  assign bram_rd_addr = rd_iss[AW-1:0];
  assign m_valid      = (ocnt != 2'd0);
  assign m_data       = obuf[orp];
  assign m_last       = m_valid && olast[orp];

endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// Bench for pkt_fifo_ctrl: frame-level queue model checked every cycle
// plus directed literal checks for latency, drops, overflow and reset.
module tb_pkt_fifo_ctrl;

  localparam int D = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_drop, s_ready;
  logic [7:0] m_data;
  logic       m_valid, m_last, m_ready;
  logic [9:0] bram_wr_addr, bram_rd_addr;
  logic       bram_wr_en;
  logic [7:0] bram_wr_data;
  logic [7:0] bram_rd_data;
  logic [4:0] frame_count;
  logic       drop_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pkt_fifo_ctrl #(.P_NUM_BRAM(1), .P_MAX_FRAMES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_drop(s_drop), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready),
    .bram_wr_addr(bram_wr_addr), .bram_wr_en(bram_wr_en),
    .bram_wr_data(bram_wr_data), .bram_rd_addr(bram_rd_addr),
    .bram_rd_data(bram_rd_data),
    .frame_count(frame_count), .drop_pulse(drop_pulse)
  );

  logic [7:0] mem [D];
  always @(posedge clk) begin
    if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
    bram_rd_data <= mem[bram_rd_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: bytes of committed frames awaiting egress.
  logic [7:0] exp_b [$];
  bit         exp_l [$];
  logic [7:0] part  [$];
  int  used_m = 0, mcount = 0, mst = 0;
  int  bytes_out = 0, drops_seen = 0;
  bit  stall = 0;
  logic [7:0] stall_data;

  always @(negedge clk) begin : mon
    bit e_ready, e_drop, e_wr;
    if (!rst_n) begin
      exp_b.delete(); exp_l.delete(); part.delete();
      used_m = 0; mcount = 0; mst = 0; stall = 0;
    end else begin
      chk("frame_count", int'(frame_count), mcount);
      e_ready = (mst != 0) || (mcount < 16);
      chk("s_ready", int'(s_ready), int'(e_ready));
      e_drop = 0;
      e_wr   = 0;
      if (s_valid && s_ready) begin
        if (mst == 2) begin
          if (s_last) mst = 0;
        end else if (used_m == D) begin
          e_drop = 1;
          used_m -= part.size();
          part.delete();
          mst = s_last ? 0 : 2;
        end else if (s_last && s_drop) begin
          e_drop = 1;
          used_m -= part.size();
          part.delete();
          mst = 0;
        end else begin
          e_wr = 1;
          part.push_back(s_data);
          used_m++;
          if (s_last) begin
            foreach (part[i]) begin
              exp_b.push_back(part[i]);
              exp_l.push_back(i == part.size() - 1);
            end
            part.delete();
            mcount++;
            mst = 0;
          end else begin
            mst = 1;
          end
        end
      end
      chk("drop_pulse", int'(drop_pulse), int'(e_drop));
      chk("bram_wr_en", int'(bram_wr_en), int'(e_wr));
      if (e_wr) chk("bram_wr_data", int'(bram_wr_data), int'(s_data));
      if (drop_pulse) drops_seen++;
      if (stall) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), int'(stall_data));
      end
      if (m_valid && m_ready) begin
        chk("egress_expected", int'(exp_b.size() > 0), 1);
        if (exp_b.size() > 0) begin
          chk("m_data", int'(m_data), int'(exp_b[0]));
          chk("m_last", int'(m_last), int'(exp_l[0]));
          if (exp_l[0]) mcount--;
          void'(exp_b.pop_front());
          void'(exp_l.pop_front());
          used_m--;
          bytes_out++;
        end
      end
      stall      = m_valid && !m_ready;
      stall_data = m_data;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l,
                           input logic dr);
    int  n = 0;
    logic ok;
    s_valid = 1'b1; s_data = d; s_last = l; s_drop = dr;
    do begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 3000);
    if (!ok) chk("send_timeout", n, 0);
    s_valid = 1'b0; s_last = 1'b0; s_drop = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] base,
                            input logic dr);
    for (int i = 0; i < len; i++)
      send_byte(base + 8'(i), i == len - 1, dr && (i == len - 1));
  endtask

  task automatic send_rand(input int len);
    for (int i = 0; i < len; i++)
      send_byte(8'($urandom), i == len - 1, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    while ((exp_b.size() != 0 || mcount != 0) && n < 8000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_done", int'(exp_b.size() == 0 && mcount == 0), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_wr_en", int'(bram_wr_en), 0);
    chk("rst_wr_addr", int'(bram_wr_addr), 0);
    chk("rst_rd_addr", int'(bram_rd_addr), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_drop", int'(drop_pulse), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b0, nv;
    logic [9:0] pre;
    bit done;
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_drop = 1'b0;
    s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_rst", int'(s_ready), 1);
    @(posedge clk);
    #1;

    // 64-byte frame: latency and back-to-back egress
    send_frame(64, 8'h00, 1'b0);
    nv = 0;
    for (int k = 1; k <= 67; k++) begin
      @(negedge clk);
      if (k == 1) chk("fc_after_commit", int'(frame_count), 1);
      if (k <= 3) chk("latency_idle", int'(m_valid), 0);
      else if (m_valid) nv++;
      if (k == 4) chk("latency_first", int'(m_data), 8'h00);
      if (k == 67) begin
        chk("last_flag", int'(m_last), 1);
        chk("last_byte", int'(m_data), 8'h3F);
      end
    end
    chk("back_to_back", nv, 64);
    @(negedge clk);
    chk("fc_back_to_0", int'(frame_count), 0);
    @(posedge clk);
    #1;

    // dropped frame then a good 10-byte frame
    pre = bram_wr_addr;
    d0 = drops_seen; b0 = bytes_out;
    send_frame(5, 8'h80, 1'b1);
    send_frame(10, 8'h90, 1'b0);
    chk("wr_ptr_after_drop", int'(bram_wr_addr), int'(pre + 10'd10));
    drain();
    chk("drop_count", drops_seen - d0, 1);
    chk("egress_10", bytes_out - b0, 10);

    // overflow while egress is held off
    m_ready = 1'b0;
    d0 = drops_seen; b0 = bytes_out;
    send_frame(1000, 8'h00, 1'b0);
    send_frame(100, 8'h10, 1'b0);
    chk("ovf_drop", drops_seen - d0, 1);
    chk("ovf_fc", int'(frame_count), 1);
    drain();
    chk("ovf_egress", bytes_out - b0, 1000);

    // frame queue limit
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_frame(1, 8'hE0 + 8'(i), 1'b0);
    @(negedge clk);
    chk("full_fc", int'(frame_count), 16);
    chk("full_ready", int'(s_ready), 0);
    @(posedge clk);
    #1;
    s_valid = 1'b1; s_last = 1'b1; s_data = 8'hF0;
    @(negedge clk);
    chk("full_blocked", int'(s_ready), 0);
    chk("full_m_valid", int'(m_valid), 1);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("pop_reenable", int'(s_ready), 1);
    chk("pop_fc", int'(frame_count), 15);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("refill_fc", int'(frame_count), 16);
    repeat (4) @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    m_ready = 1'b1;
    s_valid = 1'b1; s_last = 1'b1; s_data = 8'hF1;
    @(negedge clk);
    chk("both_valid", int'(m_valid && m_last && s_ready), 1);
    chk("both_fc_before", int'(frame_count), 15);
    @(posedge clk);
    #1;
    m_ready = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("both_fc_after", int'(frame_count), 15);
    @(posedge clk);
    #1;
    drain();

    // random back-pressure over several buffer wraps
    done = 0;
    fork
      begin
        for (int f = 0; f < 90; f++) send_rand($urandom_range(20, 120));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // reset mid-ingress and mid-egress
    send_frame(40, 8'h40, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("mid_egress", int'(m_valid), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_rst2", int'(s_ready), 1);
    @(posedge clk);
    #1;
    b0 = bytes_out;
    send_frame(8, 8'hC0, 1'b0);
    drain();
    chk("post_rst_egress", bytes_out - b0, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
